id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 48 ++++
 rtl/id_ex_stage_fwd_mux.sv | 33 +++
 rtl/id_ex_stage.sv | 146 ++++++++++++++
 tb/tb_id_ex_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, payload types and helpers for the ID/EX pipeline slot.
//   XLEN     : datapath width
//   REG_W    : register index width
//   ALU_OP_W : ALU operation code width
//   CNT_W    : bubble counter width
package id_ex_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned CNT_W    = 16;

    localparam logic [XLEN-1:0]  WORD_ZERO = '0;
    localparam logic [REG_W-1:0] REG_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Control bits carried alongside an instruction into EX.
    typedef struct packed {
        logic alu_src;
        logic mem_rd;
        logic mem_wr;
        logic reg_wr;
        logic wb_sel;
    } ex_ctrl_t;

    // Complete EX slot contents; rs/rt are kept only for operand forwarding.
    typedef struct packed {
        logic                valid;
        ex_ctrl_t            ctrl;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    rd;
        logic [XLEN-1:0]     rd1;
        logic [XLEN-1:0]     rd2;
        logic [XLEN-1:0]     imm;
        logic [ALU_OP_W-1:0] alu_op;
    } ex_slot_t;

    localparam ex_ctrl_t CTRL_NOP   = '0;
    localparam ex_slot_t SLOT_RESET = '0;

    // Saturating increment for the bubble counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding selector for one EX source operand.
//   src_idx     : register index the operand was read from
//   stored_data : value latched from the register file at capture
//   exm_*       : EX/MEM producer (highest priority)
//   mwb_*       : MEM/WB producer
//   fwd_data_c  : selected operand (combinational)
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  logic [REG_W-1:0] src_idx,
    input  logic [XLEN-1:0]  stored_data,
    input  logic             exm_reg_wr,
    input  logic [REG_W-1:0] exm_rd,
    input  logic [XLEN-1:0]  exm_result,
    input  logic             mwb_reg_wr,
    input  logic [REG_W-1:0] mwb_rd,
    input  logic [XLEN-1:0]  mwb_data,
    output logic [XLEN-1:0]  fwd_data_c
);

    // r0 is hard-wired zero, so it never takes a forwarded value.
    always_comb begin
        fwd_data_c = stored_data;
        if (src_idx == REG_ZERO) begin
            fwd_data_c = WORD_ZERO;
        end else if (exm_reg_wr && (exm_rd == src_idx)) begin
            fwd_data_c = exm_result;
        end else if (mwb_reg_wr && (mwb_rd == src_idx)) begin
            fwd_data_c = mwb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and operand forwarding.
//   clk, rst_n           : clock, async active-low reset
//   id_*                 : decoded instruction presented by ID
//   flush, hold          : squash / freeze the EX slot
//   exm_*, mwb_*         : forwarding sources from later stages
//   stall                : load-use stall request to IF/ID (combinational)
//   ex_*                 : registered EX slot, ex_op_a/b forwarded operands
//   bubble_cnt           : saturating count of load-use bubbles
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic [XLEN-1:0]     id_rd1,
    input  logic [XLEN-1:0]     id_rd2,
    input  logic [XLEN-1:0]     id_imm,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_mem_rd,
    input  logic                id_mem_wr,
    input  logic                id_reg_wr,
    input  logic                id_wb_sel,
    input  logic                flush,
    input  logic                hold,
    input  logic                exm_reg_wr,
    input  logic [REG_W-1:0]    exm_rd,
    input  logic [XLEN-1:0]     exm_result,
    input  logic                mwb_reg_wr,
    input  logic [REG_W-1:0]    mwb_rd,
    input  logic [XLEN-1:0]     mwb_data,
    output logic                stall,
    output logic                ex_valid,
    output logic [REG_W-1:0]    ex_rd,
    output logic [XLEN-1:0]     ex_imm,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_mem_rd,
    output logic                ex_mem_wr,
    output logic                ex_reg_wr,
    output logic                ex_wb_sel,
    output logic [XLEN-1:0]     ex_op_a,
    output logic [XLEN-1:0]     ex_op_b,
    output logic [CNT_W-1:0]    bubble_cnt
);

    ex_slot_t         slot_q;
    ex_slot_t         slot_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    ex_ctrl_t         id_ctrl;
    logic [XLEN-1:0]  op_a_c;
    logic [XLEN-1:0]  op_b_c;

    assign id_ctrl = '{alu_src: id_alu_src,
                       mem_rd:  id_mem_rd,
                       mem_wr:  id_mem_wr,
                       reg_wr:  id_reg_wr,
                       wb_sel:  id_wb_sel};

    // A load in EX whose destination feeds the instruction in ID.
    assign stall = slot_q.valid && slot_q.ctrl.mem_rd && id_valid &&
                   (slot_q.rd != REG_ZERO) &&
                   ((slot_q.rd == id_rs) || (slot_q.rd == id_rt));

    fwd_mux u_fwd_a (
        .src_idx     (slot_q.rs),
        .stored_data (slot_q.rd1),
        .exm_reg_wr  (exm_reg_wr),
        .exm_rd      (exm_rd),
        .exm_result  (exm_result),
        .mwb_reg_wr  (mwb_reg_wr),
        .mwb_rd      (mwb_rd),
        .mwb_data    (mwb_data),
        .fwd_data_c  (op_a_c)
    );

    fwd_mux u_fwd_b (
        .src_idx     (slot_q.rt),
        .stored_data (slot_q.rd2),
        .exm_reg_wr  (exm_reg_wr),
        .exm_rd      (exm_rd),
        .exm_result  (exm_result),
        .mwb_reg_wr  (mwb_reg_wr),
        .mwb_rd      (mwb_rd),
        .mwb_data    (mwb_data),
        .fwd_data_c  (op_b_c)
    );

    // Slot update: flush beats hold beats load-use bubble beats capture.
    // While held, the stored operands absorb any forwarded value so that a
    // producer retiring during the freeze is not lost.
    always_comb begin
        slot_d = slot_q;
        cnt_d  = cnt_q;
        if (flush) begin
            slot_d.valid = 1'b0;
            slot_d.ctrl  = CTRL_NOP;
        end else if (hold) begin
            slot_d.rd1 = op_a_c;
            slot_d.rd2 = op_b_c;
        end else if (stall) begin
            slot_d.valid = 1'b0;
            slot_d.ctrl  = CTRL_NOP;
            cnt_d        = sat_inc(cnt_q);
        end else begin
            slot_d.valid  = id_valid;
            slot_d.ctrl   = id_valid ? id_ctrl : CTRL_NOP;
            slot_d.rs     = id_rs;
            slot_d.rt     = id_rt;
            slot_d.rd     = id_rd;
            slot_d.rd1    = id_rd1;
            slot_d.rd2    = id_rd2;
            slot_d.imm    = id_imm;
            slot_d.alu_op = id_alu_op;
        end
    end

    // Slot and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= SLOT_RESET;
            cnt_q  <= CNT_ZERO;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_valid   = slot_q.valid;
    assign ex_rd      = slot_q.rd;
    assign ex_imm     = slot_q.imm;
    assign ex_alu_op  = slot_q.alu_op;
    assign ex_alu_src = slot_q.ctrl.alu_src;
    assign ex_mem_rd  = slot_q.ctrl.mem_rd;
    assign ex_mem_wr  = slot_q.ctrl.mem_wr;
    assign ex_reg_wr  = slot_q.ctrl.reg_wr;
    assign ex_wb_sel  = slot_q.ctrl.wb_sel;
    assign ex_op_a    = op_a_c;
    assign ex_op_b    = op_b_c;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run compared against a rule-level model of the EX slot.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [3:0]  id_alu_op;
    logic [4:0]  id_ctrl;   // {alu_src, mem_rd, mem_wr, reg_wr, wb_sel}
    logic        flush, hold;
    logic        exm_reg_wr;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_reg_wr;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;

    logic        stall, ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_wb_sel;
    logic [31:0] ex_op_a, ex_op_b;
    logic [15:0] bubble_cnt;
    logic [4:0]  ex_ctrl;

    assign ex_ctrl = {ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_wb_sel};

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid;
    logic [4:0]  m_ctrl, m_rs, m_rt, m_rd;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [3:0]  m_op;
    int          m_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .id_imm     (id_imm),
        .id_alu_op  (id_alu_op),
        .id_alu_src (id_ctrl[4]),
        .id_mem_rd  (id_ctrl[3]),
        .id_mem_wr  (id_ctrl[2]),
        .id_reg_wr  (id_ctrl[1]),
        .id_wb_sel  (id_ctrl[0]),
        .flush      (flush),
        .hold       (hold),
        .exm_reg_wr (exm_reg_wr),
        .exm_rd     (exm_rd),
        .exm_result (exm_result),
        .mwb_reg_wr (mwb_reg_wr),
        .mwb_rd     (mwb_rd),
        .mwb_data   (mwb_data),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_rd      (ex_rd),
        .ex_imm     (ex_imm),
        .ex_alu_op  (ex_alu_op),
        .ex_alu_src (ex_alu_src),
        .ex_mem_rd  (ex_mem_rd),
        .ex_mem_wr  (ex_mem_wr),
        .ex_reg_wr  (ex_reg_wr),
        .ex_wb_sel  (ex_wb_sel),
        .ex_op_a    (ex_op_a),
        .ex_op_b    (ex_op_b),
        .bubble_cnt (bubble_cnt)
    );

    // Operand a register would deliver given the current forwarding sources.
    function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] stored);
        if (idx == 5'd0) return 32'd0;
        if (exm_reg_wr && exm_rd == idx) return exm_result;
        if (mwb_reg_wr && mwb_rd == idx) return mwb_data;
        return stored;
    endfunction

    function automatic logic m_stall();
        return m_valid && m_ctrl[3] && id_valid && (m_rd != 5'd0) &&
               ((m_rd == id_rs) || (m_rd == id_rt));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_op = '0; m_cnt = 0;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rd1 = '0; id_rd2 = '0; id_imm = '0; id_alu_op = '0; id_ctrl = '0;
        flush = 1'b0; hold = 1'b0;
        exm_reg_wr = 1'b0; exm_rd = '0; exm_result = '0;
        mwb_reg_wr = 1'b0; mwb_rd = '0; mwb_data = '0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rd1,
                            input logic [31:0] rd2, input logic [31:0] imm,
                            input logic [3:0] op, input logic [4:0] ctrl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_alu_op = op; id_ctrl = ctrl;
    endtask

    // One rising edge: DUT and model both advance using the current inputs.
    task automatic tick();
        logic [31:0] a, b;
        logic        st;
        a  = m_fwd(m_rs, m_rd1);
        b  = m_fwd(m_rt, m_rd2);
        st = m_stall();
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0; m_ctrl = '0;
        end else if (hold) begin
            m_rd1 = a; m_rd2 = b;
        end else if (st) begin
            m_valid = 1'b0; m_ctrl = '0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_valid = id_valid; m_ctrl = id_valid ? id_ctrl : 5'd0;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm; m_op = id_alu_op;
        end
        #1;
    endtask

    task automatic test_reset();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", ex_valid); end
        checks++; if (ex_rd !== 5'd0 || ex_imm !== 32'd0 || ex_alu_op !== 4'd0) begin
            errors++; $display("FAIL reset_fields got rd=%0h imm=%0h op=%0h exp 0", ex_rd, ex_imm, ex_alu_op); end
        checks++; if (ex_ctrl !== 5'd0) begin errors++; $display("FAIL reset_ctrl got %0h exp 0", ex_ctrl); end
        checks++; if (ex_op_a !== 32'd0 || ex_op_b !== 32'd0) begin
            errors++; $display("FAIL reset_ops got a=%0h b=%0h exp 0", ex_op_a, ex_op_b); end
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0h exp 0", bubble_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0h exp 0", stall); end
    endtask

    task automatic test_capture();
        @(negedge clk);
        idle_inputs();
        drive_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h1234, 4'h2, 5'b00010);
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL capture_valid got %0h exp 1", ex_valid); end
        checks++; if (ex_op_a !== 32'h11) begin errors++; $display("FAIL capture_op_a got %0h exp 11", ex_op_a); end
        checks++; if (ex_op_b !== 32'h22) begin errors++; $display("FAIL capture_op_b got %0h exp 22", ex_op_b); end
        checks++; if (ex_rd !== 5'd9 || ex_imm !== 32'h1234 || ex_alu_op !== 4'h2 || ex_ctrl !== 5'b00010) begin
            errors++; $display("FAIL capture_fields got rd=%0h imm=%0h op=%0h ctrl=%0h", ex_rd, ex_imm, ex_alu_op, ex_ctrl); end
        // An empty decode slot must not carry control bits into EX.
        @(negedge clk);
        drive_id(1'b0, 5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h1234, 4'h2, 5'b11111);
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 5'd0) begin
            errors++; $display("FAIL capture_invalid got valid=%0h ctrl=%0h exp 0/0", ex_valid, ex_ctrl); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle_inputs();
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h8, 4'h0, 5'b01011);
        tick();
        @(negedge clk);
        drive_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h0, 32'h0, 32'h0, 4'h1, 5'b00010);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %0h exp 1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 5'd0) begin
            errors++; $display("FAIL loaduse_bubble got valid=%0h ctrl=%0h exp 0/0", ex_valid, ex_ctrl); end
        checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL loaduse_cnt got %0h exp 1", bubble_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_released got %0h exp 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
            errors++; $display("FAIL loaduse_resume got valid=%0h rd=%0h exp 1/7", ex_valid, ex_rd); end
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        idle_inputs();
        drive_id(1'b1, 5'd7, 5'd7, 5'd1, 32'h77, 32'h78, 32'h0, 4'h0, 5'b00010);
        tick();
        @(negedge clk);
        id_valid = 1'b0;
        exm_reg_wr = 1'b1; exm_rd = 5'd7; exm_result = 32'hAA;
        mwb_reg_wr = 1'b1; mwb_rd = 5'd7; mwb_data = 32'hBB;
        #1;
        checks++; if (ex_op_a !== 32'hAA) begin errors++; $display("FAIL fwd_exm got %0h exp aa", ex_op_a); end
        checks++; if (ex_op_b !== 32'hAA) begin errors++; $display("FAIL fwd_exm_b got %0h exp aa", ex_op_b); end
        exm_reg_wr = 1'b0; #1;
        checks++; if (ex_op_a !== 32'hBB) begin errors++; $display("FAIL fwd_mwb got %0h exp bb", ex_op_a); end
        mwb_reg_wr = 1'b0; #1;
        checks++; if (ex_op_a !== 32'h77 || ex_op_b !== 32'h78) begin
            errors++; $display("FAIL fwd_none got a=%0h b=%0h exp 77/78", ex_op_a, ex_op_b); end
        drive_id(1'b1, 5'd0, 5'd0, 5'd1, 32'h99, 32'h98, 32'h0, 4'h0, 5'b00010);
        tick();
        @(negedge clk);
        exm_reg_wr = 1'b1; exm_rd = 5'd0; exm_result = 32'hAA;
        mwb_reg_wr = 1'b1; mwb_rd = 5'd0; mwb_data = 32'hBB;
        #1;
        checks++; if (ex_op_a !== 32'd0 || ex_op_b !== 32'd0) begin
            errors++; $display("FAIL fwd_r0 got a=%0h b=%0h exp 0/0", ex_op_a, ex_op_b); end
    endtask

    task automatic test_hold_refresh();
        @(negedge clk);
        idle_inputs();
        drive_id(1'b1, 5'd9, 5'd10, 5'd12, 32'h1, 32'h2, 32'hCAFE, 4'h5, 5'b10010);
        tick();
        @(negedge clk);
        hold = 1'b1;
        mwb_reg_wr = 1'b1; mwb_rd = 5'd9; mwb_data = 32'h55;
        drive_id(1'b1, 5'd3, 5'd3, 5'd3, 32'h0, 32'h0, 32'h0, 4'h0, 5'b01011);
        tick();
        tick();
        @(negedge clk);
        mwb_reg_wr = 1'b0;
        #1;
        checks++; if (ex_op_a !== 32'h55) begin errors++; $display("FAIL hold_op_a got %0h exp 55", ex_op_a); end
        checks++; if (ex_op_b !== 32'h2) begin errors++; $display("FAIL hold_op_b got %0h exp 2", ex_op_b); end
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || ex_imm !== 32'hCAFE ||
                      ex_alu_op !== 4'h5 || ex_ctrl !== 5'b10010) begin
            errors++; $display("FAIL hold_fields got v=%0h rd=%0h imm=%0h op=%0h ctrl=%0h",
                               ex_valid, ex_rd, ex_imm, ex_alu_op, ex_ctrl); end
        tick();
        checks++; if (ex_op_a !== 32'h55) begin errors++; $display("FAIL hold_keep got %0h exp 55", ex_op_a); end
        @(negedge clk);
        hold = 1'b0;
    endtask

    task automatic test_flush_priority();
        int exp_cnt;
        @(negedge clk);
        idle_inputs();
        drive_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 4'h0, 5'b01011);
        tick();
        @(negedge clk);
        drive_id(1'b1, 5'd5, 5'd6, 5'd8, 32'h0, 32'h0, 32'h0, 4'h0, 5'b00010);
        flush = 1'b1; hold = 1'b1;
        exp_cnt = m_cnt;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %0h exp 1", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 5'd0) begin
            errors++; $display("FAIL flush_bubble got valid=%0h ctrl=%0h exp 0/0", ex_valid, ex_ctrl); end
        checks++; if (bubble_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL flush_cnt got %0h exp %0h", bubble_cnt, exp_cnt); end
        flush = 1'b0; hold = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        idle_inputs();
        drive_id(1'b1, 5'd4, 5'd5, 5'd6, 32'h4, 32'h5, 32'h6, 4'h3, 5'b11111);
        tick();
        @(negedge clk);
        hold = 1'b1;
        tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 5'd0 || ex_rd !== 5'd0 || ex_imm !== 32'd0) begin
            errors++; $display("FAIL areset_slot got v=%0h ctrl=%0h rd=%0h imm=%0h exp 0",
                               ex_valid, ex_ctrl, ex_rd, ex_imm); end
        checks++; if (ex_op_a !== 32'd0 || ex_op_b !== 32'd0 || bubble_cnt !== 16'd0 || stall !== 1'b0) begin
            errors++; $display("FAIL areset_rest got a=%0h b=%0h cnt=%0h stall=%0h exp 0",
                               ex_op_a, ex_op_b, bubble_cnt, stall); end
        // Release mid-stream: first edge with rst_n high is a normal capture.
        @(negedge clk);
        hold = 1'b0;
        drive_id(1'b1, 5'd4, 5'd5, 5'd6, 32'h44, 32'h55, 32'h66, 4'h3, 5'b00010);
        rst_n = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op_a !== 32'h44 || ex_op_b !== 32'h55 || ex_rd !== 5'd6) begin
            errors++; $display("FAIL rst_release got v=%0h a=%0h b=%0h rd=%0h exp 1/44/55/6",
                               ex_valid, ex_op_a, ex_op_b, ex_rd); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            idle_inputs();
            drive_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0, 4'h0, 5'b01011);
            tick();
            @(negedge clk);
            if (k == 0) begin
                force dut.cnt_q = 16'hFFFE;
                #1;
                release dut.cnt_q;
                m_cnt = 32'hFFFE;
            end
            drive_id(1'b1, 5'd2, 5'd5, 5'd3, 32'h0, 32'h0, 32'h0, 4'h0, 5'b00000);
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %0h exp 1", stall); end
            tick();
            checks++; if (bubble_cnt !== 16'hFFFF) begin
                errors++; $display("FAIL sat_cnt%0d got %0h exp ffff", k, bubble_cnt); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs      = 5'($urandom_range(0, 7));
            id_rt      = 5'($urandom_range(0, 7));
            id_rd      = 5'($urandom_range(0, 7));
            id_rd1     = $urandom;
            id_rd2     = $urandom;
            id_imm     = $urandom;
            id_alu_op  = 4'($urandom);
            id_ctrl    = 5'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            hold       = ($urandom_range(0, 6) == 0);
            exm_reg_wr = 1'($urandom);
            exm_rd     = 5'($urandom_range(0, 7));
            exm_result = $urandom;
            mwb_reg_wr = 1'($urandom);
            mwb_rd     = 5'($urandom_range(0, 7));
            mwb_data   = $urandom;
            #1;
            checks++; if (stall !== m_stall()) begin
                errors++; $display("FAIL rnd_stall@%0d got %0h exp %0h", n, stall, m_stall()); end
            checks++; if (ex_op_a !== m_fwd(m_rs, m_rd1) || ex_op_b !== m_fwd(m_rt, m_rd2)) begin
                errors++; $display("FAIL rnd_ops@%0d got %0h/%0h exp %0h/%0h", n, ex_op_a, ex_op_b,
                                   m_fwd(m_rs, m_rd1), m_fwd(m_rt, m_rd2)); end
            checks++; if (ex_valid !== m_valid || ex_ctrl !== m_ctrl || ex_rd !== m_rd ||
                          ex_imm !== m_imm || ex_alu_op !== m_op) begin
                errors++; $display("FAIL rnd_slot@%0d got v=%0h c=%0h rd=%0h imm=%0h op=%0h exp %0h/%0h/%0h/%0h/%0h",
                                   n, ex_valid, ex_ctrl, ex_rd, ex_imm, ex_alu_op,
                                   m_valid, m_ctrl, m_rd, m_imm, m_op); end
            checks++; if (bubble_cnt !== 16'(m_cnt)) begin
                errors++; $display("FAIL rnd_cnt@%0d got %0h exp %0h", n, bubble_cnt, m_cnt); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_capture();
        test_load_use();
        test_fwd_priority();
        test_hold_refresh();
        test_flush_priority();
        test_random();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
